// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, byte addressing and the ShiftRows permutation
package aes_pkg;
    localparam int AES_NB_BYTES = 16;

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    function automatic int byte_idx(input int row, input int col);
        return col * 4 + row;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8 * byte_idx(r, c) -: 8] = s[127 - 8 * byte_idx(r, (c + r) % 4) -: 8];
        return o;
    endfunction
endpackage

// File: rtl/sbox.sv
// sbox: combinational FIPS-197 forward S-box lookup
module sbox (
    input  logic [7:0] a,
    output logic [7:0] c
);
    localparam logic [0:2047] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign c = TBL[8 * int'(a) +: 8];
endmodule

// File: rtl/aes_sub_shift.sv
// aes_sub_shift: iterative SubBytes (LANES bytes per cycle) followed by ShiftRows
module aes_sub_shift
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);
    localparam int STEPS = AES_NB_BYTES / LANES;
    localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;

    state_t        state;
    logic [127:0]  st;
    logic [127:0]  nxt;
    logic [CW-1:0] cnt;
    logic [7:0]    sub [LANES];
    logic          last;

    assign last = cnt == CW'(STEPS - 1);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sbox u_sbox (.a(st[127 - 8 * (int'(cnt) * LANES + i) -: 8]), .c(sub[i]));
    end

    always_comb begin
        nxt = st;
        for (int k = 0; k < LANES; k++)
            nxt[127 - 8 * (int'(cnt) * LANES + k) -: 8] = sub[k];
    end

    // in_ready/out_valid are registered alongside state so they never see out_ready combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            st        <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    st       <= in_data;
                    cnt      <= '0;
                    state    <= SUB;
                    in_ready <= 1'b0;
                end
                SUB: begin
                    st  <= nxt;
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_data = shift_rows(st);
endmodule
